// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side UART controller with byte FIFO, register file and interrupt
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_ready_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_read_en_o,
    input  logic [3:0]  addr_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = CW - 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovr, rx_en, irq_en;
    logic [7:0]    thresh;
    logic [1:0]    sel;
    logic          empty, full, pop, push, drop, flush, ovr_clr;
    logic [7:0]    head;
    logic [8:0]    thresh_eff;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign unused_bits = ^{addr_i[1:0], wdata_i[31:8]};

    // Decode bus strobes, FIFO conditions and the pre-write read value
    always_comb begin
        sel        = addr_i[3:2];
        empty      = count == '0;
        full       = count == CW'(FIFO_DEPTH);
        head       = empty ? 8'h00 : mem[rd_ptr];
        pop        = re_i && sel == 2'd0 && !empty;
        flush      = we_i && sel == 2'd2 && wdata_i[2];
        ovr_clr    = we_i && sel == 2'd1 && wdata_i[2];
        drop       = state == CAPTURE && full && !pop;
        push       = state == CAPTURE && !drop && !flush;
        thresh_eff = {1'b0, thresh == 8'd0 ? 8'd1 : thresh};
        rd_val     = sel == 2'd0 ? {24'h0, head} :
                     sel == 2'd1 ? {8'h0, 8'(count), 13'h0, ovr, full, !empty} :
                     sel == 2'd2 ? {30'h0, irq_en, rx_en} :
                                   {24'h0, thresh};
    end

    // Capture FSM: acknowledge for one cycle, then a guard cycle while ready drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_read_en_o <= 1'b0;
        end else begin
            state        <= state == IDLE ? ((rx_ready_i && rx_en) ? CAPTURE : IDLE) :
                            state == CAPTURE ? SETTLE : IDLE;
            rx_read_en_o <= state == IDLE && rx_ready_i && rx_en;
        end
    end

    // FIFO storage; the captured byte is written only when it is accepted
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data_i;
    end

    // FIFO pointers and occupancy; flush overrides any concurrent push or pop
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Control/status registers, registered read data and interrupt level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr     <= 1'b0;
            rx_en   <= 1'b1;
            irq_en  <= 1'b0;
            thresh  <= 8'd1;
            rdata_o <= 32'h0;
            irq_o   <= 1'b0;
        end else begin
            ovr <= drop | (ovr & ~ovr_clr);
            if (we_i && sel == 2'd2) begin
                rx_en  <= wdata_i[0];
                irq_en <= wdata_i[1];
            end
            if (we_i && sel == 2'd3) thresh <= wdata_i[7:0];
            if (re_i) rdata_o <= rd_val;
            irq_o <= irq_en && ((9'(count) >= thresh_eff) || ovr);
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized and directed checks of uart_rx_ctrl against a queue-based model
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_ready_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_read_en_o;
    logic [3:0]  addr_i = 4'h0;
    logic        we_i = 1'b0;
    logic        re_i = 1'b0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        irq_o;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_ready_i(rx_ready_i), .rx_data_i(rx_data_i),
        .rx_read_en_o(rx_read_en_o), .addr_i(addr_i), .we_i(we_i), .re_i(re_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    byte unsigned q[$];
    byte unsigned src[$];
    bit        m_ovr = 0, m_rx_en = 1, m_irq_en = 0, m_ack = 0, m_irq = 0;
    bit [7:0]  m_thresh = 8'd1;
    bit [31:0] m_rdata = 0;
    int        since = 2;
    int        gap_max = 0, gap = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_update();
        bit [1:0]  sel;
        bit [31:0] rv;
        int        th;
        bit        pop, flush, drop, nack, irq_n;
        if (!rst_n) begin
            q.delete();
            m_ovr = 0; m_rx_en = 1; m_irq_en = 0; m_thresh = 8'd1;
            m_ack = 0; since = 2; m_irq = 0; m_rdata = 0;
        end else begin
            sel = addr_i[3:2];
            if (sel == 0)      rv = (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
            else if (sel == 1) rv = {8'h0, 8'(q.size()), 13'h0, m_ovr, q.size() == DEPTH, q.size() != 0};
            else if (sel == 2) rv = {30'h0, m_irq_en, m_rx_en};
            else               rv = {24'h0, m_thresh};
            th    = (m_thresh == 0) ? 1 : int'(m_thresh);
            irq_n = m_irq_en && (q.size() >= th || m_ovr);
            pop   = re_i && sel == 0 && q.size() > 0;
            flush = we_i && sel == 2 && wdata_i[2];
            drop  = m_ack && q.size() == DEPTH && !pop;
            nack  = rx_ready_i && m_rx_en && since >= 2;
            if (re_i) m_rdata = rv;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (m_ack && !drop) q.push_back(rx_data_i);
            end
            if (drop) m_ovr = 1;
            else if (we_i && sel == 1 && wdata_i[2]) m_ovr = 0;
            if (we_i && sel == 2) begin
                m_rx_en  = wdata_i[0];
                m_irq_en = wdata_i[1];
            end
            if (we_i && sel == 3) m_thresh = wdata_i[7:0];
            m_irq = irq_n;
            m_ack = nack;
            since = nack ? 0 : (since < 100 ? since + 1 : since);
        end
    endtask

    task automatic step();
        bit a;
        model_update();
        a = (rx_read_en_o === 1'b1);
        @(posedge clk);
        #1;
        check("ack", rx_read_en_o, m_ack);
        check("irq", irq_o, m_irq);
        check("rdata", rdata_o, m_rdata);
        we_i = 0;
        re_i = 0;
        if (a && rx_ready_i) begin
            rx_ready_i = 0;
            gap = gap_max > 0 ? $urandom_range(gap_max, 0) : 0;
        end else if (!rx_ready_i) begin
            if (gap > 0) gap--;
            else if (src.size() > 0) begin
                rx_data_i  = src.pop_front();
                rx_ready_i = 1;
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(bit [3:0] a, bit [31:0] d);
        addr_i = a; wdata_i = d; we_i = 1;
        step();
    endtask

    task automatic rd(bit [3:0] a);
        addr_i = a; re_i = 1;
        step();
    endtask

    task automatic rd_lit(string name, bit [3:0] a, bit [31:0] exp);
        rd(a);
        check(name, rdata_o, exp);
    endtask

    task automatic drain_src();
        int k = 0;
        while ((src.size() != 0 || rx_ready_i) && k < 300) begin
            step();
            k++;
        end
        check("drain_timeout", {31'h0, rx_ready_i | (src.size() != 0)}, 0);
        idle(3);
    endtask

    task automatic wait_ack();
        int k = 0;
        while (rx_read_en_o !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        check("wait_ack", rx_read_en_o, 1);
    endtask

    initial begin
        int n;
        int r;
        rst_n = 0;
        idle(3);
        rst_n = 1;
        rd_lit("rst_status", 4'h4, 32'h0);
        rd_lit("rst_ctrl", 4'h8, 32'h1);
        rd_lit("rst_thresh", 4'hC, 32'h1);
        check("rst_irq", irq_o, 0);
        idle(20);

        src = '{8'h41, 8'h42, 8'h43};
        drain_src();
        rd_lit("status3", 4'h4, 32'h0003_0001);
        rd_lit("data41", 4'h0, 32'h41);
        rd_lit("data42", 4'h0, 32'h42);
        rd_lit("data43", 4'h0, 32'h43);
        rd_lit("data_empty", 4'h0, 32'h0);
        rd_lit("status_empty", 4'h4, 32'h0);

        for (int i = 0; i <= 16; i++) src.push_back(8'(i));
        drain_src();
        rd_lit("status_full_ovr", 4'h4, 32'h0010_0007);
        for (int i = 0; i < 16; i++) rd_lit("data_seq", 4'h0, 32'(i));
        wr(4'h4, 32'h4);
        rd_lit("ovr_clear", 4'h4, 32'h0);

        wr(4'h8, 32'h3);
        wr(4'hC, 32'h4);
        src = '{8'hA0, 8'hA1, 8'hA2};
        drain_src();
        check("irq_below", irq_o, 0);
        src.push_back(8'hA3);
        drain_src();
        check("irq_at_thresh", irq_o, 1);
        rd_lit("irq_pop", 4'h0, 32'hA0);
        idle(2);
        check("irq_after_pop", irq_o, 0);
        for (int i = 1; i < 4; i++) rd(4'h0);

        for (int i = 0; i < 16; i++) src.push_back(8'(8'h80 + i));
        drain_src();
        rd_lit("status_full", 4'h4, 32'h0010_0003);
        src.push_back(8'h90);
        wait_ack();
        rd_lit("pop_with_capture", 4'h0, 32'h80);
        rd_lit("status_still_full", 4'h4, 32'h0010_0003);
        for (int i = 1; i < 16; i++) rd_lit("data_after_swap", 4'h0, 32'(8'h80 + i));
        rd_lit("data_swapped_in", 4'h0, 32'h90);
        src.push_back(8'h55);
        wait_ack();
        wr(4'h8, 32'h7);
        rd_lit("flush_with_push", 4'h4, 32'h0);

        wr(4'h8, 32'h0);
        src.push_back(8'h66);
        idle(50);
        rd_lit("rx_disabled", 4'h4, 32'h0);
        wr(4'h8, 32'h1);
        n = 0;
        while (rx_read_en_o !== 1'b1 && n < 5) begin
            step();
            n++;
        end
        check("enable_latency", {31'h0, n <= 2}, 1);
        idle(3);
        rd_lit("byte_after_enable", 4'h4, 32'h0001_0001);
        src.push_back(8'h77);
        wait_ack();
        rst_n = 0;
        step();
        rst_n = 1;
        check("rst_capture_ack", rx_read_en_o, 0);
        rd_lit("rst_capture_status", 4'h4, 32'h0);

        gap_max = 3;
        for (int c = 0; c < 3000; c++) begin
            if (src.size() < 4 && $urandom_range(99) < 30) src.push_back(8'($urandom));
            r = $urandom_range(99);
            if (r < 25) rd({2'b00, 2'($urandom)});
            else if (r < 35) rd(4'($urandom));
            else if (r < 38) wr(4'h8, {$urandom} & 32'hFFFF_FFF8 | {29'h0, $urandom_range(7) == 0, 1'($urandom), $urandom_range(9) != 0});
            else if (r < 42) wr(4'hC, {$urandom} & 32'hFFFF_FF00 | 32'($urandom_range(20)));
            else if (r < 45) wr(4'h4, $urandom);
            else if (r < 46) wr(4'h0, $urandom);
            else if (r < 47) begin
                rst_n = 0;
                step();
                rst_n = 1;
            end else step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between `uart_rx` and the CPU's memory-mapped peripheral bus. It watches the receiver's ready/data pair, issues the one-cycle read acknowledge, and buffers each byte in a FIFO so the CPU can drain bytes in bursts. It also provides a status/control register file, sticky overrun detection, and a level-triggered interrupt.

## Interface
- `FIFO_DEPTH`, 16, number of FIFO entries; power of two, 2..128.
- `CW`, `$clog2(FIFO_DEPTH)+1`, count width; derived, not overridden.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `rx_ready_i`  in  1  byte available from `uart_rx`; stays high until acknowledged.
- `rx_data_i`  in  8  received byte; valid while `rx_ready_i`=1.
- `rx_read_en_o`  out  1  one-cycle acknowledge to `uart_rx`; this clears its ready flag.
- `addr_i`  in  4  byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC THRESH; bits [1:0] ignored.
- `we_i`  in  1  register write strobe, one cycle.
- `re_i`  in  1  register read strobe, one cycle.
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  read data, registered.
- `irq_o`  out  1  level interrupt, registered.

## Operation
**Capture FSM** has three states:
- IDLE:
  - Goes to CAPTURE when `rx_ready_i`=1 and CTRL.rx_en=1.
  - Otherwise stays in IDLE. While rx_en=0, a byte left in `uart_rx` remains pending there.
- CAPTURE:
  - `rx_read_en_o`=1 for exactly this cycle.
  - `rx_data_i` is pushed if the FIFO is not full, or if a DATA pop happens in the same cycle.
  - Otherwise the byte is dropped and STATUS.ovr is set.
  - Always goes to SETTLE.
- SETTLE:
  - Guard cycle while `uart_rx` drops ready; `rx_read_en_o`=0.
  - Always returns to IDLE.
  - Minimum spacing between acknowledges is therefore 3 cycles.
- Clearing rx_en during CAPTURE or SETTLE does not abort; the current byte completes.

**FIFO**
- Read/write pointers are `CW-1` bits and wrap modulo `FIFO_DEPTH`.
- `count` ranges 0..`FIFO_DEPTH`.
- Push and pop in the same cycle leave `count` unchanged; both pointers advance.

**Register map**
- DATA (0x0):
  - Read returns `{24'b0, head}` and pops the head if not empty.
  - Read when empty returns 0, does not pop, and leaves `count` at 0.
  - Writes are ignored.
- STATUS (0x4): bit0 not_empty, bit1 full, bit2 ovr (sticky), bits[23:16] count (zero-extended).
  - Writing 1 to bit2 clears ovr.
  - If a drop occurs in the same cycle as that write, ovr stays 1 (set wins).
- CTRL (0x8): bit0 rx_en (reset 1), bit1 irq_en (reset 0), bit2 flush (write-only, self-clearing, reads 0).
  - Flush zeroes both pointers and `count`.
  - A push or pop in the same cycle as flush is discarded.
  - A DATA read concurrent with flush still returns the old head.
- THRESH (0xC): bits[7:0], reset 1.
  - A value of 0 is treated as 1.
  - Values above `FIFO_DEPTH` mean the threshold is never reached.
- Unmapped bits read 0.
- A write and a read in the same cycle are both performed; the read returns the pre-write value.

**Interrupt**
- `irq_o` = irq_en & ((count ≥ THRESH) | ovr), evaluated from the current-cycle state.

## Timing
- Reset (rst_n=0 at a rising edge) gives:
  - FSM=IDLE; `rx_read_en_o`=0, `rdata_o`=0, `irq_o`=0.
  - Pointers and count = 0; ovr=0.
  - rx_en=1, irq_en=0, THRESH=1.
- Reset mid-CAPTURE wins: no push; the acknowledge is deasserted at the next edge.
- `rx_ready_i` rising at edge N:
  - `rx_read_en_o`=1 in cycle N+1.
  - The byte is visible in count/STATUS from cycle N+2.
- `re_i` at edge N: `rdata_o` is valid in cycle N+1 and holds until the next read.
- The pop is reflected in `count` from cycle N+1.
- `irq_o` updates one cycle after the count/ovr/CTRL change that causes it.

## Test plan
- Reset, then read STATUS, CTRL, THRESH → 0x0, 0x1, 0x1; `irq_o`=0; `rx_read_en_o` stays 0 for 20 cycles.
- Present bytes 0x41, 0x42, 0x43 with ready/ack handshakes → each acknowledged in one cycle; STATUS count=3; DATA reads return 0x41, 0x42, 0x43, then 0x00 when empty.
- With `FIFO_DEPTH`=16, push 17 bytes 0x00..0x10 without reading → full=1, ovr=1; 16 reads return 0x00..0x0F; write STATUS bit2=1 → ovr=0.
- Set irq_en=1 and THRESH=4; push 3 bytes → `irq_o`=0; push a 4th → `irq_o`=1 one cycle after count=4; one DATA read → `irq_o`=0.
- FIFO full, with a DATA read in the same cycle as CAPTURE → no ovr, count stays 16, next read returns the second-oldest byte; separately, flush concurrent with a push → count=0.
- rx_en=0 with `rx_ready_i`=1 for 50 cycles → no acknowledge; set rx_en=1 → acknowledge within 2 cycles; assert rst_n=0 during CAPTURE → count=0 and `rx_read_en_o`=0 after the edge.
